aes_round_engine: RTL and testbench
===================================

# aes_round_engine

Iterative AES encryption datapath sitting directly downstream of key expansion. It consumes the flat expanded-key bus `w` (all `nr+1` round keys) plus one 128-bit plaintext block. It runs one AES round per clock and returns the ciphertext with a one-cycle `valid` pulse. A start/busy handshake lets a controller issue blocks back-to-back.

## Interface
- `nk`, default 4: key length in 32-bit words; carried for consistency with key expansion, not used in datapath.
- `nr`, default 10: number of rounds; legal values 10, 12, 14.
- `clk`  input  1: rising-edge clock.
- `reset`  input  1: synchronous, active-high reset.
- `start`  input  1: request to encrypt `in`; accepted only when `busy`=0.
- `in`  input  [0:127]: plaintext; bit 0 is the MSB; byte k = `in[8k+:8]`, column-major FIPS-197 state order.
- `w`  input  [0:128*(nr+1)-1]: expanded key; round key r = `w[128*r+:128]`.
- `out`  output  [0:127]: ciphertext, registered.
- `valid`  output  1: one-cycle pulse when `out` updates.
- `busy`  output  1: high while a block is in flight.

## Operation
- States: IDLE (`busy`=0) and RUN (`busy`=1). Round counter `rnd` is 4 bits.
- IDLE with `start`=1:
  - state register <= `in` ^ round key 0
  - `rnd` <= 1
  - go to RUN.
- IDLE with `start`=0: hold.
- RUN with `rnd` < `nr`:
  - state <= MixColumns(ShiftRows(SubBytes(state))) ^ round key `rnd`
  - `rnd` <= `rnd`+1.
- RUN with `rnd` == `nr` (final round):
  - `out` <= ShiftRows(SubBytes(state)) ^ round key `nr`
  - `valid` <= 1
  - go to IDLE.
- SubBytes uses 16 instances of the team's shared S-box lookup.
- MixColumns uses xtime over GF(2^8) with polynomial 0x11b.
- ShiftRows rotates row i left by i bytes.
- `start` while `busy`=1 is ignored; it is neither queued nor an error.
- `out` holds its last ciphertext until the next completion.
- `reset` forces these values in any state, including mid-block: `busy`=0, `valid`=0, `out`=0, `rnd`=0, state register=0. The in-flight block is discarded and no `valid` is produced.

## Timing
- `start` is sampled at edge E0.
- Rounds 1..`nr` execute at edges E1..E`nr`.
- `valid`=1 and the new `out` are visible in the cycle after edge E`nr`, i.e. latency `nr`+1 cycles from the `start` edge (11 for `nr`=10).
- `busy` rises the cycle after E0 and falls in the same cycle `valid` rises.
- `start` asserted in the `valid` cycle is accepted, giving a throughput of one block per `nr`+1 cycles.
- `valid` is never high for two consecutive cycles.
- With `reset` and `start` in the same cycle, `reset` wins.

## Configuration
- `AES_KEY_LATCH_EN` defined:
  - A 128*(`nr`+1)-bit key register captures `w` on the accepted `start` edge, and all rounds use the captured copy.
  - `w` may change freely after acceptance.
  - Reset clears the key register to 0.
- `AES_KEY_LATCH_EN` undefined:
  - No key register; rounds read `w` live.
  - `w` must be held stable from the `start` edge until `valid`; changing it mid-block gives undefined ciphertext.

## Test plan
- FIPS-197 App. B vector:
  - `w` = expansion of key 2b7e151628aed2a6abf7158809cf4f3c; `in` = 3243f6a8885a308d313198a2e0370734; pulse `start`.
  - Expected: `out` = 3925841d02dc09fbdc118597196a0b32, `valid` exactly 11 cycles after the start edge.
  - Internal state after E0 = 193de3bea0f4e22b9ac68d2ae9f84808.
- FIPS-197 App. C.1 vector:
  - key 000102030405060708090a0b0c0d0e0f; `in` = 00112233445566778899aabbccddeeff.
  - Expected: `out` = 69c4e0d86a7b0430d8cdb78070b4c55a.
- Back-to-back:
  - Hold `start`=1 continuously with the App. B then App. C.1 plaintexts under their respective keys.
  - Expected: two `valid` pulses 11 cycles apart with the correct ciphertexts; `start` during `busy` causes no extra pulse.
- Ignored start:
  - Pulse `start` with a different `in` 4 cycles after an accepted start.
  - Expected: ciphertext of the first block only; exactly one `valid`.
- Reset mid-block:
  - Assert `reset` at cycle 5 of a block.
  - Expected: next cycle `busy`=0, `out`=0, no `valid`; a fresh `start` then gives a correct result.
- Key latch (with `AES_KEY_LATCH_EN`):
  - Change `w` to all-zeros 2 cycles after an App. B start.
  - Expected: `out` still 3925841d02dc09fbdc118597196a0b32.

Source files
------------

// File: rtl/aes_round_engine.sv
// aes_round_engine: iterative AES encryption, one round per clock.
//   Ports:
//     clk    - rising-edge clock
//     reset  - synchronous, active-high reset
//     start  - encrypt request, accepted only while busy=0
//     in     - plaintext block; bit 0 is the MSB, byte k = in[8k+:8]
//     w      - expanded key; round key r = w[128*r+:128]
//     out    - registered ciphertext; holds until the next completion
//     valid  - one-cycle pulse when out updates
//     busy   - high while a block is in flight
//   Parameters: nk (key words, consistency check only), nr (10/12/14 rounds).
//   Optional feature macro AES_KEY_LATCH_EN: when defined, w is captured on the
//   accepted start and all rounds use that copy; otherwise w is read live.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [0:2047] SBOX = 2048'h637c777bf26b6fc53001672bfed7ab76_ca82c97dfa5947f0add4a2af9ca472c0_b7fd9326363ff7cc34a5e5f171d83115_04c723c31896059a071280e2eb27b275_09832c1a1b6e5aa0523bd6b329e32f84_53d100ed20fcb15b6acbbe394a4c58cf_d0efaafb434d338545f9027f503c9fa8_51a3408f929d38f5bcb6da2110fff3d2_cd0c13ec5f974417c4a77e3d645d1973_60814fdc222a908846eeb814de5e0bdb_e0323a0a4906245cc2d3ac629195e479_e7c8376d8dd54ea96c56f4ea657aae08_ba78252e1ca6b4c6e8dd741f4bbd8b8a_703eb5664803f60e613557b986c11d9e_e1f8981169d98e949b1e87e9ce5528df_8ca1890dbfe6426841992d0fb054bb16;

  assign y = SBOX[{a, 3'b000} +: 8];
endmodule

module aes_round_engine #(
  parameter int unsigned nk = 4,
  parameter int unsigned nr = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [0:127]           in,
  input  logic [0:128*(nr+1)-1]  w,
  output logic [0:127]           out,
  output logic                   valid,
  output logic                   busy
);
  localparam int unsigned KW       = 128 * (nr + 1);
  localparam logic [3:0]  RND_LAST = 4'(nr);

  // Reject configurations that do not describe a real AES variant.
  if (!(nr == 10 || nr == 12 || nr == 14) || nr != nk + 6) begin : g_bad_cfg
    $error("aes_round_engine: illegal nk/nr combination");
  end

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state, state_nx;
  logic [3:0]    rnd, rnd_nx;
  logic [0:127]  st, st_nx;
  logic [0:127]  out_nx;
  logic          valid_nx;
  logic [0:KW-1] key_src;
  logic [0:127]  rk, sb, sr, mc;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [0:31] mix_col(input logic [0:31] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[0:7];
    a1 = c[8:15];
    a2 = c[16:23];
    a3 = c[24:31];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

`ifdef AES_KEY_LATCH_EN
  // Key copy taken at acceptance so the caller may retarget w immediately.
  logic [0:KW-1] key_q;

  always_ff @(posedge clk) begin
    if (reset)                      key_q <= '0;
    else if (state == IDLE && start) key_q <= w;
  end

  assign key_src = key_q;
`else
  assign key_src = w;
`endif

  // SubBytes: one S-box per state byte.
  for (genvar k = 0; k < 16; k++) begin : g_sbox
    aes_sbox u_sbox (.a(st[8*k +: 8]), .y(sb[8*k +: 8]));
  end

  // ShiftRows: byte (row r, col c) takes byte (row r, col c+r mod 4).
  always_comb begin
    sr = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[8*(4*c+r) +: 8] = sb[8*(4*((c+r)%4)+r) +: 8];
      end
    end
  end

  // MixColumns over the four state columns.
  always_comb begin
    mc = '0;
    for (int c = 0; c < 4; c++) begin
      mc[32*c +: 32] = mix_col(sr[32*c +: 32]);
    end
  end

  // Round key select with constant slices only.
  always_comb begin
    rk = '0;
    for (int r = 0; r <= int'(nr); r++) begin
      if (rnd == 4'(r)) rk = key_src[128*r +: 128];
    end
  end

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rnd   <= '0;
      st    <= '0;
      out   <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_nx;
      rnd   <= rnd_nx;
      st    <= st_nx;
      out   <= out_nx;
      valid <= valid_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (rnd == RND_LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath / output next values; start during RUN falls through untouched.
  always_comb begin
    rnd_nx   = rnd;
    st_nx    = st;
    out_nx   = out;
    valid_nx = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          st_nx  = in ^ w[0:127];
          rnd_nx = 4'd1;
        end
      end
      RUN: begin
        if (rnd == RND_LAST) begin
          out_nx   = sr ^ rk;
          valid_nx = 1'b1;
          rnd_nx   = '0;
        end else begin
          st_nx  = mc ^ rk;
          rnd_nx = rnd + 4'd1;
        end
      end
      default: ;
    endcase
  end

  assign busy = (state == RUN);
endmodule

// File: tb/tb_aes_round_engine.sv
// Scoreboard bench for aes_round_engine using FIPS-197 vectors.
module tb_aes_round_engine;
  localparam logic [0:2047] SBOX = 2048'h637c777bf26b6fc53001672bfed7ab76_ca82c97dfa5947f0add4a2af9ca472c0_b7fd9326363ff7cc34a5e5f171d83115_04c723c31896059a071280e2eb27b275_09832c1a1b6e5aa0523bd6b329e32f84_53d100ed20fcb15b6acbbe394a4c58cf_d0efaafb434d338545f9027f503c9fa8_51a3408f929d38f5bcb6da2110fff3d2_cd0c13ec5f974417c4a77e3d645d1973_60814fdc222a908846eeb814de5e0bdb_e0323a0a4906245cc2d3ac629195e479_e7c8376d8dd54ea96c56f4ea657aae08_ba78252e1ca6b4c6e8dd741f4bbd8b8a_703eb5664803f60e613557b986c11d9e_e1f8981169d98e949b1e87e9ce5528df_8ca1890dbfe6426841992d0fb054bb16;

  localparam logic [0:127] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [0:127] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [0:127] ST0_B = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [0:127] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [0:127]  pt;
  logic [0:1407] kw;
  logic [0:127]  ct;
  logic          valid;
  logic          busy;

  logic [0:1407] kb, kc;
  int unsigned   cyc = 0;
  int            errors = 0;
  int            checks = 0;
  logic          prev_valid = 1'b0;

  typedef struct {
    logic [127:0] data;
    int unsigned  due;
  } exp_t;
  exp_t sb_q[$];
  exp_t e;

  aes_round_engine dut (
    .clk(clk), .reset(reset), .start(start), .in(pt), .w(kw),
    .out(ct), .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] sbx(input logic [7:0] x);
    return SBOX[{x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // AES-128 key schedule producing the flat 44-word bus.
  function automatic logic [0:1407] expand(input logic [0:127] key);
    logic [31:0] wd [0:43];
    logic [31:0] t;
    logic [7:0]  rcon;
    logic [0:1407] res;
    for (int i = 0; i < 4; i++) wd[i] = key[32*i +: 32];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = wd[i-1];
      if (i % 4 == 0) begin
        t = {sbx(t[23:16]), sbx(t[15:8]), sbx(t[7:0]), sbx(t[31:24])} ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      wd[i] = wd[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) res[32*i +: 32] = wd[i];
    return res;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one start pulse and record the expected completion.
  task automatic issue(input logic [0:127] p, input logic [0:1407] k, input logic [0:127] c);
    @(negedge clk);
    start = 1'b1;
    pt    = p;
    kw    = k;
    sb_q.push_back('{data: c, due: cyc + 11});
    @(negedge clk);
    start = 1'b0;
  endtask

  // Monitor: compare every valid pulse against the scoreboard head.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      check("valid_gap", 128'(prev_valid), 128'(0));
      check("busy_at_valid", 128'(busy), 128'(0));
      if (sb_q.size() == 0) begin
        check("spurious_valid", 128'(valid), 128'(0));
      end else begin
        e = sb_q.pop_front();
        check("ciphertext", ct, e.data);
        check("latency", 128'(cyc), 128'(e.due));
      end
    end
    prev_valid = (valid === 1'b1);
  end

  initial begin
    kb    = expand(KEY_B);
    kc    = expand(KEY_C);
    reset = 1'b1;
    start = 1'b0;
    pt    = '0;
    kw    = '0;
    repeat (3) @(negedge clk);
    check("reset_out", ct, 128'(0));
    check("reset_valid", 128'(valid), 128'(0));
    check("reset_busy", 128'(busy), 128'(0));
    reset = 1'b0;
    @(negedge clk);

    // App. B vector, internal state after the first edge, then hold.
    issue(PT_B, kb, CT_B);
    check("state_after_e0", dut.st, ST0_B);
    check("busy_after_e0", 128'(busy), 128'(1));
    repeat (12) @(negedge clk);
    check("out_hold", ct, CT_B);
    check("valid_low_after", 128'(valid), 128'(0));

    // App. C.1 vector.
    issue(PT_C, kc, CT_C);
    repeat (12) @(negedge clk);

    // Back-to-back with start held high throughout.
    @(negedge clk);
    start = 1'b1;
    pt    = PT_B;
    kw    = kb;
    sb_q.push_back('{data: CT_B, due: cyc + 11});
    repeat (11) @(negedge clk);
    pt = PT_C;
    kw = kc;
    sb_q.push_back('{data: CT_C, due: cyc + 11});
    repeat (11) @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);

    // Start while busy is ignored.
    issue(PT_B, kb, CT_B);
    repeat (3) @(negedge clk);
    start = 1'b1;
    pt    = PT_C;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);

    // Reset at cycle 5 of a block discards it.
    issue(PT_C, kc, CT_C);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    void'(sb_q.pop_back());
    @(negedge clk);
    reset = 1'b0;
    check("midreset_busy", 128'(busy), 128'(0));
    check("midreset_out", ct, 128'(0));
    check("midreset_valid", 128'(valid), 128'(0));
    repeat (12) @(negedge clk);
    issue(PT_B, kb, CT_B);
    repeat (12) @(negedge clk);

    // Reset wins over a simultaneous start.
    reset = 1'b1;
    start = 1'b1;
    pt    = PT_C;
    kw    = kc;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check("rst_start_busy", 128'(busy), 128'(0));
    @(negedge clk);
    check("rst_start_busy2", 128'(busy), 128'(0));
    check("rst_start_valid", 128'(valid), 128'(0));

`ifdef AES_KEY_LATCH_EN
    // Key bus wiped two cycles after acceptance.
    issue(PT_B, kb, CT_B);
    @(negedge clk);
    kw = '0;
    repeat (11) @(negedge clk);
    kw = kb;
`endif

    repeat (15) @(negedge clk);
    check("scoreboard_drained", 128'(sb_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
